// File: rtl/rom_reader_pkg.sv
// rtl/rom_reader_pkg.sv - shared FSM state type and reset constants for the ROM stream reader
package rom_reader_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } rd_state_e;

   localparam logic RST_FLAG = 1'b0;
   localparam int unsigned RST_VALUE = 0;

endpackage

// File: rtl/rom_stream_fifo2.sv
// rtl/rom_stream_fifo2.sv - two-entry FIFO holding ROM words and their last-of-burst flag
module rom_stream_fifo2 #(
   parameter int DATA_WIDTH = 9
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push_i,
   input  logic [DATA_WIDTH-1:0] push_data_i,
   input  logic                  push_last_i,
   input  logic                  pop_i,
   output logic [DATA_WIDTH-1:0] data_o,
   output logic                  last_o,
   output logic [1:0]            count_o
);
   import rom_reader_pkg::*;

   logic [DATA_WIDTH-1:0] data_q [2];
   logic                  last_q [2];
   logic                  wr_ptr_q;
   logic                  rd_ptr_q;
   logic [1:0]            count_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 2; i++) begin
            data_q[i] <= DATA_WIDTH'(RST_VALUE);
            last_q[i] <= RST_FLAG;
         end
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         if (push_i) begin
            data_q[wr_ptr_q] <= push_data_i;
            last_q[wr_ptr_q] <= push_last_i;
            wr_ptr_q         <= ~wr_ptr_q;
         end
         if (pop_i) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         case ({push_i, pop_i})
            2'b10:   count_q <= count_q + 2'd1;
            2'b01:   count_q <= count_q - 2'd1;
            default: count_q <= count_q;
         endcase
      end
   end

   assign data_o  = data_q[rd_ptr_q];
   assign last_o  = last_q[rd_ptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/rom_stream_reader.sv
// rtl/rom_stream_reader.sv - burst reader streaming ROM words with backpressure
// ROM_READER_WRAP_EN: addresses wrap at DEPTH-1 instead of rejecting out-of-range bursts
module rom_stream_reader #(
   parameter  int DATA_WIDTH = 9,
   parameter  int DEPTH      = 5,
   localparam int ADDR_WIDTH = $clog2(DEPTH),
   localparam int CNT_WIDTH  = ADDR_WIDTH + 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] start_addr,
   input  logic [CNT_WIDTH-1:0]  count,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   output logic                  rom_rd_en,
   output logic [ADDR_WIDTH-1:0] rom_addr,
   input  logic [DATA_WIDTH-1:0] rom_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_last
);
   import rom_reader_pkg::*;

   rd_state_e             state_q;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [CNT_WIDTH-1:0]  left_q;
   logic                  inflight_q;
   logic                  inflight_last_q;
   logic                  done_q;
   logic                  err_q;
   logic [1:0]            fifo_count;
   logic [DATA_WIDTH-1:0] fifo_data;
   logic                  fifo_last;
   logic                  fifo_pop;
   logic [2:0]            occ;
   logic                  start_bad;

`ifdef ROM_READER_WRAP_EN
   assign start_bad = 1'b0;
`else
   logic [CNT_WIDTH:0] end_sum;
   assign end_sum   = {1'b0, CNT_WIDTH'(start_addr)} + {1'b0, count};
   assign start_bad = (CNT_WIDTH'(start_addr) >= CNT_WIDTH'(DEPTH)) ||
                      (end_sum > (CNT_WIDTH+1)'(DEPTH));
`endif

   assign out_valid = (fifo_count != 2'd0);
   assign fifo_pop  = out_valid && out_ready;

   // A read may issue only if its word is guaranteed a FIFO slot when it lands.
   always_comb begin
      occ       = {1'b0, fifo_count} + {2'b00, inflight_q};
      rom_rd_en = (state_q == ST_RUN) && (occ < (fifo_pop ? 3'd3 : 3'd2));
      addr_d    = addr_q;
      if (rom_rd_en) begin
         addr_d = (addr_q == ADDR_WIDTH'(DEPTH-1)) ? '0 : addr_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= ST_IDLE;
         addr_q          <= ADDR_WIDTH'(RST_VALUE);
         left_q          <= CNT_WIDTH'(RST_VALUE);
         inflight_q      <= RST_FLAG;
         inflight_last_q <= RST_FLAG;
         done_q          <= RST_FLAG;
         err_q           <= RST_FLAG;
      end else begin
         done_q          <= 1'b0;
         err_q           <= 1'b0;
         inflight_q      <= rom_rd_en;
         inflight_last_q <= rom_rd_en && (left_q == CNT_WIDTH'(1));
         addr_q          <= addr_d;
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  if (start_bad) begin
                     err_q <= 1'b1;
                  end else if (count == '0) begin
                     done_q <= 1'b1;
                  end else begin
                     state_q <= ST_RUN;
                     addr_q  <= start_addr;
                     left_q  <= count;
                  end
               end
            end
            ST_RUN: begin
               if (rom_rd_en) begin
                  left_q <= left_q - 1'b1;
                  if (left_q == CNT_WIDTH'(1)) begin
                     state_q <= ST_DRAIN;
                  end
               end
            end
            ST_DRAIN: begin
               if (fifo_pop && fifo_last) begin
                  state_q <= ST_IDLE;
                  done_q  <= 1'b1;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   rom_stream_fifo2 #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .push_i      (inflight_q),
      .push_data_i (rom_data),
      .push_last_i (inflight_last_q),
      .pop_i       (fifo_pop),
      .data_o      (fifo_data),
      .last_o      (fifo_last),
      .count_o     (fifo_count)
   );

   assign busy     = (state_q != ST_IDLE);
   assign done     = done_q;
   assign err      = err_q;
   assign rom_addr = addr_q;
   assign out_data = fifo_data;
   assign out_last = fifo_last && out_valid;

endmodule

// File: tb/tb_rom_stream_reader.sv
// tb/tb_rom_stream_reader.sv - scoreboard bench for rom_stream_reader at DEPTH=5, DATA_WIDTH=9
module tb_rom_stream_reader;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [2:0] start_addr = '0;
   logic [3:0] count = '0;
   logic       busy, done, err, rom_rd_en, out_valid, out_last;
   logic [2:0] rom_addr;
   logic [8:0] rom_data = '0;
   logic       out_ready = 1'b0;
   logic [8:0] out_data;

   logic [8:0] rom_mem [5] = '{9'h1FB, 9'h101, 9'h000, 9'h0FF, 9'h1FF};
   logic [9:0] exp_q [$];
   int tests_run = 0;
   int tests_failed = 0;

   logic       prev_stall = 1'b0;
   logic [8:0] prev_data = '0;
   logic       prev_last = 1'b0;

   always #5 clk = ~clk;

   rom_stream_reader #(.DATA_WIDTH(9), .DEPTH(5)) dut (
      .clk(clk), .rst(rst), .start(start), .start_addr(start_addr), .count(count),
      .busy(busy), .done(done), .err(err), .rom_rd_en(rom_rd_en), .rom_addr(rom_addr),
      .rom_data(rom_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_last(out_last)
   );

   always @(posedge clk) begin
      if (rom_rd_en) rom_data <= (rom_addr < 3'd5) ? rom_mem[rom_addr] : 9'h000;
   end

   // Scoreboard pop on every transfer, plus hold check on stalled words.
   always @(negedge clk) begin
      logic [9:0] e;
      if (rst) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            tests_run++;
            if (out_valid !== 1'b1 || out_data !== prev_data || out_last !== prev_last) begin
               tests_failed++;
               $display("FAIL stall_hold got v=%b d=%h l=%b exp v=1 d=%h l=%b",
                        out_valid, out_data, out_last, prev_data, prev_last);
            end
         end
         if (out_valid && out_ready) begin
            tests_run++;
            if (exp_q.size() == 0) begin
               tests_failed++;
               $display("FAIL sb_unexpected got d=%h l=%b exp no word", out_data, out_last);
            end else begin
               e = exp_q.pop_front();
               if ({out_last, out_data} !== e) begin
                  tests_failed++;
                  $display("FAIL sb_word got l=%b d=%h exp l=%b d=%h", out_last, out_data, e[9], e[8:0]);
               end
            end
         end
         prev_stall = out_valid && !out_ready;
         prev_data  = out_data;
         prev_last  = out_last;
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input int a, input int c, input bit push);
      start      = 1'b1;
      start_addr = 3'(a);
      count      = 4'(c);
      if (push) begin
         for (int i = 0; i < c; i++) exp_q.push_back({(i == c-1) ? 1'b1 : 1'b0, rom_mem[(a+i)%5]});
      end
   endtask

   task automatic start_burst(input int a, input int c, input bit push);
      issue(a, c, push);
      cyc();
      start = 1'b0;
   endtask

   task automatic wait_done(input string name, input int bound);
      bit seen = 0;
      for (int k = 0; k < bound && !seen; k++) begin
         @(negedge clk);
         if (done) seen = 1;
         cyc();
      end
      tests_run++;
      if (!seen) begin
         tests_failed++;
         $display("FAIL %s_done_timeout got no done exp done within %0d cycles", name, bound);
      end
      tests_run++;
      if (exp_q.size() != 0) begin
         tests_failed++;
         $display("FAIL %s_sb_empty got %0d left exp 0", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      cyc(); cyc();
      @(negedge clk);
      tests_run++;
      if ({busy, done, err, rom_rd_en, out_valid, out_last, rom_addr, out_data} !== 18'd0) begin
         tests_failed++;
         $display("FAIL reset_values got %b exp 0", {busy, done, err, rom_rd_en, out_valid, out_last, rom_addr, out_data});
      end
      cyc();
      rst = 1'b0;
      cyc();
   endtask

   task automatic test_full_burst();
      logic [3:0] exp;
      out_ready = 1'b1;
      start_burst(0, 5, 1);
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         exp = {k <= 7, k >= 3 && k <= 7, k <= 5, k == 8};
         tests_run++;
         if ({busy, out_valid, rom_rd_en, done} !== exp) begin
            tests_failed++;
            $display("FAIL full_burst T+%0d busy/valid/rd/done got %b exp %b", k, {busy, out_valid, rom_rd_en, done}, exp);
         end
         cyc();
      end
      tests_run++;
      if (exp_q.size() != 0) begin
         tests_failed++;
         $display("FAIL full_burst_sb_empty got %0d left exp 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_backpressure();
      bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      bit seen = 0;
      out_ready = 1'b0;
      start_burst(1, 3, 1);
      for (int k = 1; k <= 40 && !seen; k++) begin
         out_ready = (k >= 3) ? pat[(k-3)%4] : 1'b0;
         @(negedge clk);
         if (done) seen = 1;
         cyc();
      end
      tests_run++;
      if (!seen) begin
         tests_failed++;
         $display("FAIL backpressure_done got none exp done within 40 cycles");
      end
      tests_run++;
      if (exp_q.size() != 0) begin
         tests_failed++;
         $display("FAIL backpressure_sb_empty got %0d left exp 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_range();
      out_ready = 1'b1;
`ifdef ROM_READER_WRAP_EN
      start_burst(3, 4, 1);
      wait_done("range_wrap", 20);
`else
      start_burst(3, 4, 0);
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         tests_run++;
         if ({err, busy, rom_rd_en, out_valid} !== {k == 1, 3'b000}) begin
            tests_failed++;
            $display("FAIL range_reject T+%0d err/busy/rd/valid got %b exp %b", k, {err, busy, rom_rd_en, out_valid}, {k == 1, 3'b000});
         end
         cyc();
      end
`endif
   endtask

   task automatic test_zero_count();
      out_ready = 1'b1;
      start_burst(2, 0, 0);
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         tests_run++;
         if ({done, busy, rom_rd_en, out_valid, err} !== {k == 1, 4'b0000}) begin
            tests_failed++;
            $display("FAIL zero_count T+%0d done/busy/rd/valid/err got %b exp %b", k, {done, busy, rom_rd_en, out_valid, err}, {k == 1, 4'b0000});
         end
         cyc();
      end
   endtask

   task automatic test_reset_mid_burst();
      out_ready = 1'b0;
      start_burst(0, 5, 0);
      cyc(); cyc(); cyc();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      @(negedge clk);
      tests_run++;
      if ({busy, done, err, rom_rd_en, out_valid, out_last, rom_addr, out_data} !== 18'd0) begin
         tests_failed++;
         $display("FAIL reset_mid_values got %b exp 0", {busy, done, err, rom_rd_en, out_valid, out_last, rom_addr, out_data});
      end
      for (int k = 0; k < 4; k++) begin
         cyc();
         @(negedge clk);
         tests_run++;
         if ({done, busy, out_valid} !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset_mid_quiet cyc %0d done/busy/valid got %b exp 000", k, {done, busy, out_valid});
         end
      end
      cyc();
      out_ready = 1'b1;
      start_burst(4, 1, 1);
      wait_done("reset_restart", 20);
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b1;
      start_burst(0, 2, 1);
      cyc();
      issue(3, 1, 0);
      @(negedge clk);
      tests_run++;
      if (busy !== 1'b1) begin
         tests_failed++;
         $display("FAIL b2b_busy_run got %b exp 1", busy);
      end
      cyc();
      start = 1'b0;
      cyc(); cyc();
      issue(2, 2, 1);
      @(negedge clk);
      tests_run++;
      if ({done, busy} !== 2'b10) begin
         tests_failed++;
         $display("FAIL b2b_done_cycle done/busy got %b exp 10", {done, busy});
      end
      cyc();
      start = 1'b0;
      @(negedge clk);
      tests_run++;
      if ({rom_rd_en, busy, rom_addr} !== {2'b11, 3'd2}) begin
         tests_failed++;
         $display("FAIL b2b_restart rd/busy/addr got %b exp %b", {rom_rd_en, busy, rom_addr}, {2'b11, 3'd2});
      end
      wait_done("b2b", 20);
   endtask

   initial begin
      test_reset();
      test_full_burst();
      test_backpressure();
      test_range();
      test_zero_count();
      test_reset_mid_burst();
      test_back_to_back();
      cyc(); cyc();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
